console_refresh_scheduler: RTL

Sequences the 8-line text console for the command printer. Owns the 8x32 character line history, scrolls it when the PS/2 line buffer commits a line, and replays the visible region into the display character RAM over a ready/valid write port. Sits between the PS/2 line assembler and the VGA character memory, and replaces free-running print loops with a single controlled sweep per event.

---
 rtl/console_refresh_scheduler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/console_refresh_scheduler.sv
// Console line history with scroll-on-commit and a single
// controlled replay sweep into the display character RAM.
module console_refresh_scheduler #(
  parameter int LINES      = 8,
  parameter int COLS       = 32,
  parameter int VIS_COLS   = 12,
  parameter int ROW_STRIDE = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [COLS*8-1:0] line_content,
  input  logic              line_commit,
  input  logic              refresh_req,
  input  logic              char_ready,
  output logic              char_we,
  output logic [7:0]        char_index,
  output logic [7:0]        char_data,
  output logic              busy,
  output logic              done,
  output logic              commit_overrun
);

  localparam int RW = $clog2(LINES);
  localparam int CW = $clog2(COLS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCROLL = 2'd1;
  localparam logic [1:0] S_SWEEP  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          pcommit_q, pcommit_d;
  logic          prefresh_q, prefresh_d;
  logic          ovr_q, ovr_d;
  logic          stage_we;
  logic          accept;

  // Byte c of a row lives at element COLS-1-c, matching line_content.
  logic [COLS-1:0][7:0] hist_q [LINES];
  logic [COLS-1:0][7:0] stage_q;

  // The staged line is being consumed in SCROLL, so a commit there is kept.
  assign accept = line_commit &&
                  (!pcommit_q || state_q == S_SCROLL);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    pcommit_d  = pcommit_q;
    prefresh_d = prefresh_q | refresh_req;
    ovr_d      = ovr_q;
    stage_we   = 1'b0;
    if (line_commit) begin
      if (accept) stage_we = 1'b1;
      else        ovr_d    = 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (pcommit_q || line_commit) begin
          state_d = S_SCROLL;
        end else if (prefresh_q || refresh_req) begin
          state_d    = S_SWEEP;
          row_d      = '0;
          col_d      = '0;
          prefresh_d = 1'b0;
        end
      end
      S_SCROLL: begin
        state_d    = S_SWEEP;
        row_d      = '0;
        col_d      = '0;
        prefresh_d = 1'b0;
        pcommit_d  = 1'b0;
      end
      S_SWEEP: begin
        if (char_ready) begin
          if (col_q == CW'(VIS_COLS-1)) begin
            col_d = '0;
            if (row_q == RW'(LINES-1)) state_d = S_DONE;
            else                       row_d   = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) pcommit_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      pcommit_q  <= 1'b0;
      prefresh_q <= 1'b0;
      ovr_q      <= 1'b0;
      stage_q    <= '0;
      for (int r = 0; r < LINES; r++) hist_q[r] <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pcommit_q  <= pcommit_d;
      prefresh_q <= prefresh_d;
      ovr_q      <= ovr_d;
      if (stage_we) stage_q <= line_content;
      if (state_q == S_SCROLL) begin
        for (int r = 0; r < LINES-1; r++) hist_q[r] <= hist_q[r+1];
        hist_q[LINES-1] <= stage_q;
      end
    end
  end

  assign char_we        = (state_q == S_SWEEP);
  assign char_index     = char_we ?
                          8'(row_q) * 8'(ROW_STRIDE) + 8'(col_q) : 8'h00;
  assign char_data      = char_we ?
                          hist_q[row_q][CW'(COLS-1) - col_q] : 8'h00;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign commit_overrun = ovr_q;

endmodule
